mem_dbus: RTL and testbench
===========================

// Module: mem_dbus
// PURPOSE
//  MEM stage. Sits between the EX/MEM register and the MEM/WB register.
//  Runs load/store instructions as handshaked data-bus cycles and raises stallreq while a cycle is open.
//  Formats load data (byte/half, signed/unsigned, big-endian lanes).
//  Passes non-memory results, including HI/LO write info, straight through to MEM/WB.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles without dbus_ack before the access is aborted (>=2)
//  CNT_W           8    width of timeout counter; 2**CNT_W must be >= TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  wd_i         in   5   dest reg addr from EX/MEM
//  wreg_i       in   1   reg write enable from EX/MEM
//  wdata_i      in   32  ALU result from EX/MEM
//  whilo_i      in   1   HI/LO write enable
//  hi_i         in   32  HI write data
//  lo_i         in   32  LO write data
//  aluop_i      in   8   op code; LB/LBU/LH/LHU/LW/SB/SH/SW per defines.v
//  mem_addr_i   in   32  effective address
//  reg2_i       in   32  store data
//  ctrl_signal  in   6   pipeline stall vector from ctrl; bit 4 = MEM/WB stage stalled
//  mem_wd       out  5   to MEM/WB
//  mem_wreg     out  1   to MEM/WB
//  mem_wdata    out  32  to MEM/WB
//  mem_whilo    out  1   to MEM/WB
//  mem_hi       out  32  to MEM/WB
//  mem_lo       out  32  to MEM/WB
//  stallreq     out  1   to ctrl; combinational
//  dbus_req     out  1   bus request; registered
//  dbus_we      out  1   1 = write; registered
//  dbus_addr    out  32  word address {addr[31:2],2'b00}; registered
//  dbus_sel     out  4   byte lanes, bit 3 = bits 31:24; registered
//  dbus_wdata   out  32  store data replicated to lanes; registered
//  dbus_ack     in   1   slave done; valid only while dbus_req=1
//  dbus_rdata   in   32  read data, valid with dbus_ack
//  bus_err      out  1   1-cycle pulse on timeout abort; combinational
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rbuf=0, all dbus_* outputs 0; bus_err=0 and stallreq=0 that cycle.
//  memop = aluop_i is one of the 8 load/store ops AND the address is aligned.
//  Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0:
//    no bus cycle, mem_wreg forced 0, other fields pass through.
//  Lane select, addr[1:0]=00..11:
//    byte -> sel 1000/0100/0010/0001; half (00/10) -> 1100/0011; word -> 1111.
//    SB replicates {4{b}}, SH {2{h}}, SW the word.
//  States:
//  IDLE:
//    memop -> stallreq=1; next edge latch dbus_*, dbus_req=1, cnt=0, go BUSY.
//    non-memop -> outputs = inputs, stallreq=0.
//  BUSY, no ack and cnt<TIMEOUT_CYCLES-1: stallreq=1, cnt++, bus outputs held stable.
//  BUSY, ack or timeout (cnt==TIMEOUT_CYCLES-1):
//    - stallreq=0; load result is formatted from dbus_rdata (0 on timeout); bus_err=1 on timeout.
//    - Next edge: dbus_req=0, rbuf<=formatted data.
//    - If ctrl_signal[4]=0, go IDLE; otherwise go HOLD.
//    - ack wins when ack and timeout happen in the same cycle.
//  HOLD: stallreq=0, no new request; load result from rbuf; leave to IDLE when ctrl_signal[4]=0.
//  Load result: LB/LH sign-extend; LBU/LHU zero-extend; mem_wdata=result; stores keep mem_wreg=0.
//  One bus cycle per instruction. Back-to-back memops return to IDLE first; min 2 cycles/access.
//  Reset mid-BUSY drops dbus_req the next edge; the access is abandoned with no data returned.
// TESTING
//  LW addr 0x100, slave acks 3 cycles after req, rdata 0x8899AABB
//    -> stallreq high 3 cycles, mem_wdata=0x8899AABB, mem_wreg=1 on the ack cycle.
//  LB addr 0x103, rdata 0x123456F0 -> sel=0001, mem_wdata=0xFFFFFFF0; LBU -> 0x000000F0.
//  SH addr 0x102, reg2=0x0000BEEF -> dbus_we=1, sel=0011, wdata=0xBEEFBEEF, mem_wreg=0.
//  LW addr 0x101 -> no dbus_req, stallreq=0, mem_wreg=0.
//  No ack for TIMEOUT_CYCLES -> bus_err 1-cycle pulse, mem_wdata=0, stallreq drops, req=0 next edge.
//  Ack while ctrl_signal[4]=1 -> HOLD, data held from rbuf, IDLE on release; rst mid-BUSY -> all 0.

Source files
------------

// File: rtl/mem_dbus_if.sv
// mem_dbus_if: handshaked data-bus between the MEM stage (master) and memory (slave).
//   dbus_req   master->slave  bus request, held until the slave acks or the master aborts
//   dbus_we    master->slave  1 = write
//   dbus_addr  master->slave  word address, low two bits zero
//   dbus_sel   master->slave  byte lanes, bit 3 = data bits 31:24
//   dbus_wdata master->slave  store data replicated across lanes
//   dbus_ack   slave->master  access done; meaningful only while dbus_req=1
//   dbus_rdata slave->master  read data, valid with dbus_ack
interface mem_dbus_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_dbus.sv
// mem_dbus: MEM pipeline stage between EX/MEM and MEM/WB.
//   Runs aligned load/store ops as one handshaked bus cycle each, stalling the
//   pipeline while the cycle is open; formats load data (byte/half, signed or
//   unsigned, big-endian lanes); passes everything else straight to MEM/WB.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wd_i..lo_i          EX/MEM results (dest reg, write enable, ALU data, HI/LO)
//   aluop_i             operation code
//   mem_addr_i, reg2_i  effective address, store data
//   ctrl_signal         stall vector; bit 4 = MEM/WB stalled
//   mem_*               to MEM/WB
//   stallreq            stall request to ctrl (combinational)
//   bus_err             one-cycle pulse when an access is aborted on timeout
//   dbus                data-bus master port (registered request side)
module mem_dbus #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [5:0]  ctrl_signal,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stallreq,
  output logic        bus_err,
  mem_dbus_if.master  dbus
);
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              req_q, req_d, we_q, we_d;
  logic [31:0]       addr_q, addr_d, bwdata_q, bwdata_d;
  logic [3:0]        sel_q, sel_d;

  logic is_load, is_store, is_signed, sz_byte, sz_half, sz_word;
  logic misaligned, memop, cnt_last, done;
  logic [3:0]  sel_calc;
  logic [31:0] wdata_calc, ld_fmt, load_res;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        ctrl_unused;

  assign ctrl_unused = ^{ctrl_signal[5], ctrl_signal[3:0]};

  // Decode and lane steering.
  always_comb begin
    is_load = 1'b0; is_store = 1'b0; is_signed = 1'b0;
    sz_byte = 1'b0; sz_half = 1'b0; sz_word = 1'b0;
    case (aluop_i)
      OP_LB:  begin is_load  = 1'b1; sz_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; sz_half = 1'b1; is_signed = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_SB:  begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
    misaligned = (sz_half & mem_addr_i[0]) | (sz_word & (|mem_addr_i[1:0]));
    memop      = (is_load | is_store) & ~misaligned;

    sel_calc   = 4'b1111;
    wdata_calc = reg2_i;
    if (sz_byte) begin
      sel_calc   = 4'b1000 >> mem_addr_i[1:0];
      wdata_calc = {4{reg2_i[7:0]}};
    end else if (sz_half) begin
      sel_calc   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_calc = {2{reg2_i[15:0]}};
    end

    case (mem_addr_i[1:0])
      2'b00:   lane_b = dbus.dbus_rdata[31:24];
      2'b01:   lane_b = dbus.dbus_rdata[23:16];
      2'b10:   lane_b = dbus.dbus_rdata[15:8];
      default: lane_b = dbus.dbus_rdata[7:0];
    endcase
    lane_h = mem_addr_i[1] ? dbus.dbus_rdata[15:0] : dbus.dbus_rdata[31:16];

    if (sz_byte)      ld_fmt = {{24{is_signed & lane_b[7]}}, lane_b};
    else if (sz_half) ld_fmt = {{16{is_signed & lane_h[15]}}, lane_h};
    else              ld_fmt = dbus.dbus_rdata;

    // Ack takes priority over a coinciding timeout.
    load_res = dbus.dbus_ack ? ld_fmt : '0;
    cnt_last = (cnt_q == CNT_LAST);
    done     = (state_q == S_BUSY) && (dbus.dbus_ack || cnt_last);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rbuf_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rbuf_q   <= rbuf_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      bwdata_q <= bwdata_d;
    end
  end

  // Next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rbuf_d   = rbuf_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    bwdata_d = bwdata_q;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          state_d  = S_BUSY;
          cnt_d    = '0;
          req_d    = 1'b1;
          we_d     = is_store;
          addr_d   = {mem_addr_i[31:2], 2'b00};
          sel_d    = sel_calc;
          bwdata_d = wdata_calc;
        end
      end
      S_BUSY: begin
        if (done) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          rbuf_d  = load_res;
          state_d = ctrl_signal[4] ? S_HOLD : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (!ctrl_signal[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_wd    = wd_i;
    mem_wreg  = wreg_i;
    mem_wdata = wdata_i;
    mem_whilo = whilo_i;
    mem_hi    = hi_i;
    mem_lo    = lo_i;
    stallreq  = 1'b0;
    bus_err   = 1'b0;
    if (misaligned || (memop && is_store)) begin
      mem_wreg = 1'b0;
    end else if (memop) begin
      case (state_q)
        S_BUSY:  mem_wdata = load_res;
        S_HOLD:  mem_wdata = rbuf_q;
        default: mem_wdata = '0;
      endcase
    end
    case (state_q)
      S_IDLE:  stallreq = memop;
      S_BUSY:  begin
        stallreq = !done;
        bus_err  = cnt_last && !dbus.dbus_ack;
      end
      default: ;
    endcase
    if (rst) begin
      stallreq = 1'b0;
      bus_err  = 1'b0;
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_sel   = sel_q;
  assign dbus.dbus_wdata = bwdata_q;
endmodule

// File: tb/tb_mem_dbus.sv
module tb_mem_dbus;
  localparam int unsigned TO = 6;
  localparam logic [7:0] OP_LB = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5,
                         OP_LW = 8'hE3, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB,
                         OP_ADD = 8'h20, OP_NOP = 8'h00;

  logic clk = 1'b0, rst;
  logic [4:0] wd_i; logic wreg_i; logic [31:0] wdata_i; logic whilo_i;
  logic [31:0] hi_i, lo_i; logic [7:0] aluop_i; logic [31:0] mem_addr_i, reg2_i;
  logic [5:0] ctrl_signal;
  logic [4:0] mem_wd; logic mem_wreg; logic [31:0] mem_wdata; logic mem_whilo;
  logic [31:0] mem_hi, mem_lo; logic stallreq, bus_err;

  mem_dbus_if bus ();

  mem_dbus #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .ctrl_signal(ctrl_signal),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .stallreq(stallreq), .bus_err(bus_err), .dbus(bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, wdata, rdata;
    int unsigned dly;
    bit          hold, memop, we;
    logic [3:0]  sel;
    logic [31:0] bw, res;
    bit          wreg;
  } vec_t;

  typedef struct {
    bit memop, mis, load, store;
    logic [3:0] sel;
    logic [31:0] bw, result;
  } exp_t;

  // Reference model: derived from the access rules with plain arithmetic.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] reg2, input logic [31:0] rdata);
    exp_t e;
    int unsigned sz = 0, idx = addr % 4;
    bit sgn = 0;
    longint v;
    e.load = 0; e.store = 0;
    case (op)
      OP_LB:  begin sz = 1; sgn = 1; e.load = 1; end
      OP_LBU: begin sz = 1; e.load = 1; end
      OP_LH:  begin sz = 2; sgn = 1; e.load = 1; end
      OP_LHU: begin sz = 2; e.load = 1; end
      OP_LW:  begin sz = 4; e.load = 1; end
      OP_SB:  begin sz = 1; e.store = 1; end
      OP_SH:  begin sz = 2; e.store = 1; end
      OP_SW:  begin sz = 4; e.store = 1; end
      default: ;
    endcase
    e.mis   = (sz == 2 && idx % 2 != 0) || (sz == 4 && idx != 0);
    e.memop = (sz != 0) && !e.mis;
    e.sel = 4'hF; e.bw = reg2; e.result = rdata;
    if (sz == 1) begin
      e.sel = 4'(1 << (3 - idx));
      e.bw  = (reg2 % 256) * 32'h0101_0101;
      v = longint'((rdata >> ((3 - idx) * 8)) % 256);
      if (sgn && v >= 128) v -= 256;
      e.result = 32'(v);
    end else if (sz == 2) begin
      e.sel = 4'(3 << (2 - idx));
      e.bw  = (reg2 % 65536) * 32'h0001_0001;
      v = longint'((rdata >> ((2 - idx) * 8)) % 65536);
      if (sgn && v >= 32768) v -= 65536;
      e.result = 32'(v);
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, reg2, wdata, rdata,
                              input int unsigned dly, input bit hold, memop, we,
                              input logic [3:0] sel, input logic [31:0] bw, res, input bit wreg);
    vec_t t;
    t.op = op; t.addr = addr; t.reg2 = reg2; t.wdata = wdata; t.rdata = rdata;
    t.dly = dly; t.hold = hold; t.memop = memop; t.we = we; t.sel = sel;
    t.bw = bw; t.res = res; t.wreg = wreg;
    return t;
  endfunction

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_access(input vec_t v, input string tag);
    int unsigned stalls = 0;
    logic [4:0] wd; logic [31:0] hi, lo;
    wd = 5'($urandom); hi = $urandom; lo = $urandom;
    aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2; wdata_i = v.wdata;
    wreg_i = 1'b1; wd_i = wd; hi_i = hi; lo_i = lo; whilo_i = 1'b1;
    ctrl_signal = v.hold ? 6'h10 : 6'h00;
    bus.dbus_ack = 1'b0; bus.dbus_rdata = $urandom;
    @(negedge clk);
    chk({tag, " stall_idle"}, 32'(stallreq), 32'(v.memop));
    chk({tag, " pass_wd"}, 32'(mem_wd), 32'(wd));
    chk({tag, " pass_hi"}, mem_hi, hi);
    chk({tag, " pass_lo"}, mem_lo, lo);
    if (stallreq) stalls++;
    if (!v.memop) begin
      chk({tag, " nomem_wreg"}, 32'(mem_wreg), 32'(v.wreg));
      chk({tag, " nomem_wdata"}, mem_wdata, v.res);
      chk({tag, " nomem_req"}, 32'(bus.dbus_req), 0);
      @(posedge clk); #1;
      aluop_i = OP_NOP;
      return;
    end
    for (int k = 0; k <= int'(v.dly); k++) begin
      @(posedge clk); #1;
      bus.dbus_ack   = (k == int'(v.dly));
      bus.dbus_rdata = (k == int'(v.dly)) ? v.rdata : $urandom;
      @(negedge clk);
      if (stallreq) stalls++;
      if (k == 0) begin
        chk({tag, " req"}, 32'(bus.dbus_req), 1);
        chk({tag, " we"}, 32'(bus.dbus_we), 32'(v.we));
        chk({tag, " baddr"}, bus.dbus_addr, v.addr & ~32'd3);
        chk({tag, " sel"}, 32'(bus.dbus_sel), 32'(v.sel));
        if (v.we) chk({tag, " bwdata"}, bus.dbus_wdata, v.bw);
      end
      if (k == int'(v.dly)) begin
        chk({tag, " err_on_ack"}, 32'(bus_err), 0);
        chk({tag, " wreg"}, 32'(mem_wreg), 32'(v.wreg));
        if (!v.we) chk({tag, " ldata"}, mem_wdata, v.res);
      end
    end
    chk({tag, " stall_cycles"}, stalls, v.dly + 1);
    @(posedge clk); #1;
    bus.dbus_ack = 1'b0; bus.dbus_rdata = $urandom;
    if (v.hold) begin
      @(negedge clk);
      chk({tag, " hold_req"}, 32'(bus.dbus_req), 0);
      chk({tag, " hold_stall"}, 32'(stallreq), 0);
      if (!v.we) chk({tag, " hold_data"}, mem_wdata, v.res);
      @(posedge clk); #1;
      ctrl_signal = 6'h00;
      @(negedge clk);
      if (!v.we) chk({tag, " release_data"}, mem_wdata, v.res);
      @(posedge clk); #1;
      aluop_i = OP_NOP;
      @(negedge clk);
      chk({tag, " after_hold_req"}, 32'(bus.dbus_req), 0);
      @(posedge clk); #1;
    end else begin
      aluop_i = OP_NOP;
      @(negedge clk);
      chk({tag, " done_req"}, 32'(bus.dbus_req), 0);
      chk({tag, " done_stall"}, 32'(stallreq), 0);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[14];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv; exp_t e;
    logic [7:0] ops[10];
    int unsigned to_k;
    bit seen;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD, OP_NOP};

    //           op      addr        reg2         wdata        rdata       dly hold mem we sel    bw            res           wreg
    tbl[0]  = mk(OP_LW,  32'h100, 32'h0,        32'h0,        32'h8899AABB, 2, 0, 1, 0, 4'hF, 32'h0,        32'h8899AABB, 1);
    tbl[1]  = mk(OP_LB,  32'h103, 32'h0,        32'h0,        32'h123456F0, 1, 0, 1, 0, 4'h1, 32'h0,        32'hFFFFFFF0, 1);
    tbl[2]  = mk(OP_LBU, 32'h103, 32'h0,        32'h0,        32'h123456F0, 1, 0, 1, 0, 4'h1, 32'h0,        32'h000000F0, 1);
    tbl[3]  = mk(OP_SH,  32'h102, 32'h0000BEEF, 32'h0,        32'h0,        0, 0, 1, 1, 4'h3, 32'hBEEFBEEF, 32'h0,        0);
    tbl[4]  = mk(OP_LW,  32'h101, 32'h0,        32'h11112222, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h11112222, 0);
    tbl[5]  = mk(OP_ADD, 32'h104, 32'h0,        32'hCAFEF00D, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'hCAFEF00D, 1);
    tbl[6]  = mk(OP_LH,  32'h200, 32'h0,        32'h0,        32'h80017FFF, 1, 0, 1, 0, 4'hC, 32'h0,        32'hFFFF8001, 1);
    tbl[7]  = mk(OP_LHU, 32'h202, 32'h0,        32'h0,        32'h80018002, 0, 0, 1, 0, 4'h3, 32'h0,        32'h00008002, 1);
    tbl[8]  = mk(OP_SB,  32'h301, 32'h123456A5, 32'h0,        32'h0,        1, 0, 1, 1, 4'h4, 32'hA5A5A5A5, 32'h0,        0);
    tbl[9]  = mk(OP_SW,  32'h304, 32'hDEADBEEF, 32'h0,        32'h0,        3, 1, 1, 1, 4'hF, 32'hDEADBEEF, 32'h0,        0);
    tbl[10] = mk(OP_LB,  32'h100, 32'h0,        32'h0,        32'h7F000000, 0, 1, 1, 0, 4'h8, 32'h0,        32'h0000007F, 1);
    tbl[11] = mk(OP_SH,  32'h101, 32'h0,        32'h33334444, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h33334444, 0);
    tbl[12] = mk(OP_LW,  32'h400, 32'h0,        32'h0,        32'h01020304, 5, 0, 1, 0, 4'hF, 32'h0,        32'h01020304, 1);
    tbl[13] = mk(OP_LH,  32'h202, 32'h0,        32'h0,        32'h0000F00F, 4, 0, 1, 0, 4'h3, 32'h0,        32'hFFFFF00F, 1);

    // Reset with a load presented: nothing may start.
    rst = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h100; reg2_i = '0; wdata_i = '0;
    wreg_i = 1'b1; wd_i = '0; whilo_i = 1'b0; hi_i = '0; lo_i = '0; ctrl_signal = '0;
    bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stallreq), 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_req", 32'(bus.dbus_req), 0);
    chk("rst_sel", 32'(bus.dbus_sel), 0);
    chk("rst_addr", bus.dbus_addr, 0);
    chk("rst_wdata", bus.dbus_wdata, 0);
    chk("rst_we", 32'(bus.dbus_we), 0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = OP_NOP;
    @(posedge clk); #1;

    foreach (tbl[i]) run_access(tbl[i], $sformatf("vec%0d", i));

    // Timeout: no ack ever; result 0 and a single bus_err pulse.
    aluop_i = OP_LW; mem_addr_i = 32'h500; wreg_i = 1'b1; ctrl_signal = '0;
    bus.dbus_ack = 1'b0;
    @(posedge clk); #1;
    seen = 0; to_k = 0;
    for (int k = 0; k < int'(TO) + 2 && !seen; k++) begin
      @(negedge clk);
      if (bus_err) begin
        seen = 1; to_k = k;
        chk("to_data", mem_wdata, 0);
        chk("to_stall", 32'(stallreq), 0);
      end
      @(posedge clk); #1;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_cycle", to_k, TO - 1);
    aluop_i = OP_NOP;
    @(negedge clk);
    chk("to_req_drop", 32'(bus.dbus_req), 0);
    chk("to_err_pulse", 32'(bus_err), 0);
    @(posedge clk); #1;

    // Reset in the middle of a busy access.
    aluop_i = OP_SW; mem_addr_i = 32'h600; reg2_i = 32'h55AA55AA;
    repeat (2) @(posedge clk);
    #1;
    chk("rb_req_before", 32'(bus.dbus_req), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_stall", 32'(stallreq), 0);
    chk("rb_err", 32'(bus_err), 0);
    @(posedge clk); #1;
    chk("rb_req", 32'(bus.dbus_req), 0);
    chk("rb_wdata", bus.dbus_wdata, 0);
    chk("rb_sel", 32'(bus.dbus_sel), 0);
    rst = 1'b0; aluop_i = OP_NOP;
    @(posedge clk); #1;

    // Randomised accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      rv.op    = ops[$urandom_range(0, 9)];
      rv.addr  = $urandom;
      rv.reg2  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.dly   = $urandom_range(0, TO - 1);
      rv.hold  = ($urandom_range(0, 3) == 0);
      e = model(rv.op, rv.addr, rv.reg2, rv.rdata);
      rv.memop = e.memop;
      rv.we    = e.store;
      rv.sel   = e.sel;
      rv.bw    = e.bw;
      rv.res   = e.memop ? e.result : rv.wdata;
      rv.wreg  = e.memop ? e.load : !e.mis;
      run_access(rv, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
